itcm_loader: RTL and testbench
==============================

Name: itcm_loader

Overview:
- Write-side companion to the instruction TCM: accepts 32-bit instruction words over a valid/ready stream and turns each into four byte writes on the ITCM byte write port (`wen_a`/`addr_a`/`in_a`).
- Byte order is little-endian, with an auto-incrementing address, so a 32-bit read at the word base returns the original word.
- Sits between the boot/debug download path and the ITCM.
- Drives `busy` so the core can be held off while a program is loaded.

Parameters:
- ADDR_W, 32 (equals `PC_SIZE`): width of byte addresses.
- MEM_BYTES, 512: usable ITCM byte capacity; legal byte addresses are 0..MEM_BYTES-1.
- CNT_W, 8: width of the word-count input.

Ports:
- clk        input   1       rising-edge clock.
- rst_n      input   1       asynchronous active-low reset.
- start      input   1       one-cycle load request; sampled only in IDLE.
- abort      input   1       synchronous cancel; highest priority after reset.
- base_addr  input   ADDR_W  first byte address; must be word aligned.
- word_cnt   input   CNT_W   number of 32-bit words to load.
- s_valid    input   1       stream word valid.
- s_ready    output  1       loader can accept a word.
- s_data     input   32      instruction word.
- wen_a      output  1       ITCM byte write enable.
- addr_a     output  ADDR_W  ITCM byte address.
- in_a       output  8       ITCM write data byte.
- busy       output  1       load in progress (core hold).
- done       output  1       one-cycle pulse at end of a load.
- err        output  1       sticky; request rejected.

Behaviour:
- Reset: all outputs are registered. While rst_n=0: wen_a=0, addr_a=0, in_a=0, s_ready=0, busy=0, done=0, err=0, state=IDLE, internal pointer/count/byte index=0.
- Reset mid-load: the FSM stops immediately. Bytes already written stay in the ITCM. No done pulse.
- States: IDLE, CHECK, WAIT, WRITE, FIN.
- IDLE, on start=1:
  - Latch ptr<=base_addr and rem<=word_cnt.
  - Clear err.
  - Go to CHECK with busy=1.
- CHECK (1 cycle):
  - The request is illegal if base_addr[1:0]!=0, or if base_addr+4*word_cnt > MEM_BYTES. Compute this in ADDR_W+CNT_W+2 bits, with no wrap.
  - Illegal: err<=1, go to FIN, no writes.
  - word_cnt==0: go to FIN, no writes, err stays 0.
  - Otherwise: go to WAIT.
- WAIT:
  - s_ready=1.
  - Handshake occurs when s_valid&&s_ready in the same cycle: capture s_data, set s_ready<=0, set idx<=0, go to WRITE.
  - s_valid without s_ready is ignored.
- WRITE (exactly 4 cycles per word):
  - Each cycle: wen_a=1, addr_a=ptr, in_a=word[8*idx+7:8*idx].
  - The next cycle has ptr+1 and idx+1.
  - First byte write is the cycle after the handshake.
  - After idx==3: rem<=rem-1. If rem-1==0, go to FIN; else go to WAIT.
  - wen_a is low in every cycle outside WRITE.
  - Minimum 5 cycles per word.
- FIN (1 cycle):
  - done=1 and busy=0 in the cycle after FIN is entered.
  - Return to IDLE.
  - err persists until the next accepted start.
- start while busy is ignored.
- abort=1 in any non-IDLE state: return to IDLE next cycle with wen_a=0, s_ready=0, busy=0, no done. A partially written word is left as is.
- abort and start together in IDLE: abort wins, the start is ignored.
- addr_a holds its last value when idle; in_a is don't-care when wen_a=0. The bench checks in_a only while wen_a=1.

Decomposition:
- Shared defines: reuse `PC_SIZE` from `cpu_define.v`.
- Add to `cpu_define.v`:
  - `ITCM_BYTES` (512)
  - loader state encodings `LD_IDLE`, `LD_CHECK`, `LD_WAIT`, `LD_WRITE`, `LD_FIN` (3-bit).
- Single module. No sub-module is needed: the byte serializer is a 2-bit index mux inside the WRITE state.

Test Plan:
1. Basic load:
   - Stimulus: start with base_addr=0x10, word_cnt=2; words 0x00500093 and 0x00A00113, s_valid always high.
   - Response: writes at 0x10..0x17 of 93,00,50,00,13,01,A0,00; done one cycle after the last write; a 32-bit read at 0x10 gives 0x00500093.
2. Backpressure/gaps:
   - Stimulus: s_valid toggles 1-0-0-1 between words.
   - Response: no writes during gaps; s_ready=0 during all WRITE cycles; exactly 4 wen_a cycles per word; byte order correct.
3. Illegal requests:
   - Stimulus: base_addr=0x02, word_cnt=1 → Response: err=1, done pulses, zero wen_a cycles.
   - Stimulus: base_addr=0x1FC, word_cnt=2 → Response: err=1, no writes.
   - Stimulus: base_addr=0x1FC, word_cnt=1 → Response: legal, writes 0x1FC..0x1FF.
4. Zero count:
   - Stimulus: word_cnt=0.
   - Response: done two cycles after start, err=0, no writes, s_ready never asserted.
5. Abort/reset mid-word:
   - Stimulus: abort asserted after the 2nd byte write.
   - Response: IDLE next cycle, wen_a=0, no done.
   - Stimulus: rst_n low mid-WRITE.
   - Response: all outputs 0 asynchronously, then a new start loads correctly.
6. Start while busy:
   - Stimulus: second start with base_addr=0x100 during a load.
   - Response: ignored; addresses continue from the first base; a single done pulse.

Source files
------------

// File: rtl/itcm_loader_pkg.sv
// Shared constants and types for the ITCM download path.
// PC_SIZE matches the core program-counter width; ITCM_BYTES is the usable ITCM size.
package itcm_loader_pkg;

    localparam int PC_SIZE    = 32;
    localparam int ITCM_BYTES = 512;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_CHECK = 3'd1,
        LD_WAIT  = 3'd2,
        LD_WRITE = 3'd3,
        LD_FIN   = 3'd4
    } ld_state_t;

    // Little-endian byte lane select of a 32-bit instruction word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/itcm_loader.sv
// Streams 32-bit words into the ITCM byte port as four little-endian byte writes at an auto-incrementing address.
// Latency: first byte write the cycle after the handshake, 4 write cycles per word, >=5 cycles per word overall.
// Backpressure: s_ready is high only while waiting for a word; it drops for the whole serialisation of that word.
module itcm_loader
    import itcm_loader_pkg::*;
#(
    parameter int ADDR_W    = PC_SIZE,
    parameter int MEM_BYTES = ITCM_BYTES,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              wen_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [7:0]        in_a,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SUM_W = ADDR_W + CNT_W + 2;
    localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_BYTES);

    ld_state_t         state_q, state_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic [CNT_W-1:0]  rem_q, rem_n;
    logic [1:0]        idx_q, idx_n;
    logic [31:0]       word_q, word_n;
    logic              wen_q, wen_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        in_q, in_n;
    logic              rdy_q, rdy_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;

    // End address is evaluated wide enough that a huge count cannot wrap back into range.
    logic [SUM_W-1:0] end_addr;
    logic             illegal;

    assign end_addr = SUM_W'(ptr_q) + SUM_W'({rem_q, 2'b00});
    assign illegal  = (ptr_q[1:0] != 2'b00) || (end_addr > MEM_LIMIT);

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        rem_n   = rem_q;
        idx_n   = idx_q;
        word_n  = word_q;
        wen_n   = 1'b0;
        addr_n  = addr_q;
        in_n    = in_q;
        rdy_n   = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;
        err_n   = err_q;

        case (state_q)
            LD_IDLE: begin
                busy_n = 1'b0;
                if (start && !abort) begin
                    ptr_n   = base_addr;
                    rem_n   = word_cnt;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = LD_CHECK;
                end
            end
            LD_CHECK: begin
                if (illegal) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = LD_FIN;
                end else if (rem_q == '0) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = LD_FIN;
                end else begin
                    rdy_n   = 1'b1;
                    state_n = LD_WAIT;
                end
            end
            LD_WAIT: begin
                rdy_n = 1'b1;
                if (s_valid && rdy_q) begin
                    word_n  = s_data;
                    idx_n   = 2'd0;
                    rdy_n   = 1'b0;
                    wen_n   = 1'b1;
                    addr_n  = ptr_q;
                    in_n    = s_data[7:0];
                    state_n = LD_WRITE;
                end
            end
            LD_WRITE: begin
                ptr_n = ptr_q + ADDR_W'(1);
                if (idx_q != 2'd3) begin
                    idx_n  = idx_q + 2'd1;
                    wen_n  = 1'b1;
                    addr_n = ptr_q + ADDR_W'(1);
                    in_n   = byte_sel(word_q, idx_q + 2'd1);
                end else begin
                    rem_n = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = LD_FIN;
                    end else begin
                        rdy_n   = 1'b1;
                        state_n = LD_WAIT;
                    end
                end
            end
            LD_FIN: begin
                busy_n  = 1'b0;
                state_n = LD_IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = LD_IDLE;
            end
        endcase

        // Cancel leaves any partially written word in the ITCM and suppresses done.
        if (abort && state_q != LD_IDLE) begin
            state_n = LD_IDLE;
            wen_n   = 1'b0;
            rdy_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            err_n   = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            in_q    <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            rem_q   <= rem_n;
            idx_q   <= idx_n;
            word_q  <= word_n;
            wen_q   <= wen_n;
            addr_q  <= addr_n;
            in_q    <= in_n;
            rdy_q   <= rdy_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    assign s_ready = rdy_q;
    assign wen_a   = wen_q;
    assign addr_a  = addr_q;
    assign in_a    = in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_itcm_loader.sv
// Directed bench for itcm_loader: logs every byte write into a byte-array ITCM model and
// compares write sequences, handshake timing, done/err behaviour, abort and reset against hand-computed values.
module tb_itcm_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [7:0]  word_cnt;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        wen_a;
    logic [31:0] addr_a;
    logic [7:0]  in_a;
    logic        busy;
    logic        done;
    logic        err;

    itcm_loader #(.ADDR_W(32), .MEM_BYTES(512), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .wen_a     (wen_a),
        .addr_a    (addr_a),
        .in_a      (in_a),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write log and ITCM model, sampled on the falling edge.
    logic [7:0]  mem [0:511];
    logic [31:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int cyc = 0;
    int wr_cnt, done_cnt, rdy_cnt, overlap_cnt;
    int start_cyc, done_cyc, last_wr_cyc;
    logic [31:0] exp_w [0:3];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wen_a) begin
            mem[addr_a[8:0]] = in_a;
            wr_addr.push_back(addr_a);
            wr_data.push_back(in_a);
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start) start_cyc = cyc;
        if (s_ready) rdy_cnt++;
        if (s_ready && wen_a) overlap_cnt++;
    end

    function automatic logic [31:0] rd_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cnt = 0; done_cnt = 0; rdy_cnt = 0; overlap_cnt = 0;
        start_cyc = 0; done_cyc = 0; last_wr_cyc = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    endtask

    // All stimulus tasks enter and leave 1 time unit after a rising edge.
    task automatic req(input logic [31:0] base, input logic [7:0] cnt);
        base_addr = base;
        word_cnt  = cnt;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (s_ready) break;
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= bound) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_writes(input logic [31:0] base, input int nw);
        logic [31:0] w;
        check("wr_count", wr_cnt, nw * 4);
        for (int i = 0; i < nw * 4 && i < wr_addr.size(); i++) begin
            w = exp_w[i / 4];
            check("wr_addr", wr_addr[i], base + i);
            check("wr_data", {24'd0, wr_data[i]}, {24'd0, w[8*(i%4) +: 8]});
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_cnt = '0; s_valid = 1'b0; s_data = '0;
        clear_log();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wen", wen_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_in", in_a, 0);
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. Basic load, s_valid held high
        clear_log();
        exp_w[0] = 32'h00500093; exp_w[1] = 32'h00A00113;
        req(32'h10, 8'd2);
        check("t1_busy", busy, 1);
        send_word(exp_w[0], 0);
        s_valid = 1'b1;
        send_word(exp_w[1], 0);
        wait_done(20);
        check_writes(32'h10, 2);
        check("t1_done_lat", done_cyc - last_wr_cyc, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_rd10", rd_word(32'h10), 32'h00500093);
        check("t1_rd14", rd_word(32'h14), 32'h00A00113);
        check("t1_err", err, 0);
        check("t1_busy_end", busy, 0);

        // 2. Gaps between words
        clear_log();
        exp_w[0] = 32'hDEADBEEF; exp_w[1] = 32'h12345678; exp_w[2] = 32'hCAFEF00D;
        req(32'h40, 8'd3);
        send_word(exp_w[0], 0);
        send_word(exp_w[1], 6);
        send_word(exp_w[2], 3);
        wait_done(20);
        check_writes(32'h40, 3);
        check("t2_overlap", overlap_cnt, 0);
        check("t2_rd48", rd_word(32'h48), 32'hCAFEF00D);
        check("t2_done_cnt", done_cnt, 1);

        // 3. Illegal and boundary requests
        clear_log();
        req(32'h02, 8'd1);
        wait_done(10);
        check("t3a_err", err, 1);
        check("t3a_wr", wr_cnt, 0);
        check("t3a_done", done_cnt, 1);
        check("t3a_ready", rdy_cnt, 0);

        clear_log();
        req(32'h1FC, 8'd2);
        wait_done(10);
        check("t3b_err", err, 1);
        check("t3b_wr", wr_cnt, 0);

        clear_log();
        exp_w[0] = 32'h11223344;
        req(32'h1FC, 8'd1);
        send_word(exp_w[0], 1);
        wait_done(20);
        check("t3c_err", err, 0);
        check_writes(32'h1FC, 1);
        check("t3c_rd", rd_word(32'h1FC), 32'h11223344);

        // 4. Zero count
        clear_log();
        req(32'h20, 8'd0);
        wait_done(10);
        check("t4_done_lat", done_cyc - start_cyc, 2);
        check("t4_err", err, 0);
        check("t4_wr", wr_cnt, 0);
        check("t4_ready", rdy_cnt, 0);

        // 5a. Abort during the second byte write
        clear_log();
        req(32'h80, 8'd1);
        send_word(32'hA1B2C3D4, 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5a_wen", wen_a, 0);
        check("t5a_busy", busy, 0);
        check("t5a_ready", s_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t5a_done", done_cnt, 0);
        check("t5a_wr", wr_cnt, 2);
        check("t5a_b0", mem[9'h80], 8'hD4);
        check("t5a_b1", mem[9'h81], 8'hC3);

        // 5b. Reset mid-WRITE, then a clean load
        req(32'h100, 8'd1);
        send_word(32'h55667788, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t5b_wen", wen_a, 0);
        check("t5b_addr", addr_a, 0);
        check("t5b_busy", busy, 0);
        check("t5b_ready", s_ready, 0);
        check("t5b_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_log();
        exp_w[0] = 32'h0BADCAFE;
        req(32'h20, 8'd1);
        send_word(exp_w[0], 0);
        wait_done(20);
        check_writes(32'h20, 1);
        check("t5b_rd", rd_word(32'h20), 32'h0BADCAFE);
        check("t5b_done_cnt", done_cnt, 1);

        // 6. Start while busy is ignored
        clear_log();
        exp_w[0] = 32'h01020304; exp_w[1] = 32'hF0E0D0C0;
        req(32'h60, 8'd2);
        send_word(exp_w[0], 0);
        req(32'h100, 8'd1);
        send_word(exp_w[1], 0);
        wait_done(20);
        check_writes(32'h60, 2);
        check("t6_done_cnt", done_cnt, 1);
        repeat (4) @(posedge clk);
        #1;
        check("t6_idle_busy", busy, 0);
        check("t6_addr_hold", addr_a, 32'h67);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
